// File: rtl/bemicro_cv_vtimer_pkg.sv
// Shared definitions for the virtual-timer scheduler.
//   TICK_W        : width of the shared tick counter and of deadlines/periods
//   MAX_CH        : largest supported channel count (one bit per channel in a 16-bit word)
//   ADDR_*        : Avalon-MM word addresses of the register map
//   deadline_reached : wrap-safe "tick has reached deadline" test
package bemicro_cv_vtimer_pkg;

  localparam int unsigned TICK_W = 32;
  localparam int unsigned MAX_CH = 16;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_ENABLE  = 4'd1;
  localparam logic [3:0] ADDR_TICK_L  = 4'd2;
  localparam logic [3:0] ADDR_TICK_H  = 4'd3;
  localparam logic [3:0] ADDR_SEL     = 4'd4;
  localparam logic [3:0] ADDR_CMP_L   = 4'd5;
  localparam logic [3:0] ADDR_CMP_H   = 4'd6;
  localparam logic [3:0] ADDR_PER_L   = 4'd7;
  localparam logic [3:0] ADDR_PER_H   = 4'd8;
  localparam logic [3:0] ADDR_ARMED   = 4'd9;
  localparam logic [3:0] ADDR_OVERRUN = 4'd10;

  // Modulo-2^32 difference read as signed: valid while the true distance
  // between tick and deadline stays below 2^31.
  function automatic logic deadline_reached(input logic [TICK_W-1:0] tick,
                                            input logic [TICK_W-1:0] deadline);
    logic [TICK_W-1:0] delta;
    delta = tick - deadline;
    return ~delta[TICK_W-1];
  endfunction

endpackage

// File: rtl/bemicro_cv_tick_gen.sv
// Prescaler plus free-running 32-bit tick counter.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   tick         : tick count, increments once every PRESCALE clocks, wraps at 2^32
//   tick_stb     : one-cycle pulse in the cycle after tick has incremented
module bemicro_cv_tick_gen
  import bemicro_cv_vtimer_pkg::*;
#(
  parameter int unsigned       PRESCALE  = 80000,
  parameter logic [TICK_W-1:0] TICK_INIT = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [TICK_W-1:0] tick,
  output logic              tick_stb
);

  localparam int unsigned     PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] RELOAD = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc    <= RELOAD;
      tick     <= TICK_INIT;
      tick_stb <= 1'b0;
    end else if (presc == '0) begin
      presc    <= RELOAD;
      tick     <= tick + TICK_W'(1);
      tick_stb <= 1'b1;
    end else begin
      presc    <= presc - PS_W'(1);
      tick_stb <= 1'b0;
    end
  end

endmodule

// File: rtl/bemicro_cv_vtimer_sched.sv
// Virtual-timer scheduler: NUM_CH one-shot/periodic deadlines share one tick
// counter and one comparator, scanned round-robin one channel per clock.
// Ports:
//   clk, reset_n      : system clock, asynchronous active-low reset
//   address[3:0]      : Avalon-MM word address
//   chipselect        : slave select
//   write_n           : active-low write strobe (read when high with chipselect)
//   writedata[15:0]   : write data
//   readdata[15:0]    : registered read data, one cycle latency
//   irq               : |(pending & enable)
// Optional: define VTIMER_OVERRUN_EN to add the OVERRUN register at address 10.
// TICK_INIT sets the tick reset value; leave it at 0 in normal use.
module bemicro_cv_vtimer_sched
  import bemicro_cv_vtimer_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 4,
  parameter int unsigned       PRESCALE  = 80000,
  parameter logic [TICK_W-1:0] TICK_INIT = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..16");
  end
  if (PRESCALE < NUM_CH) begin : g_bad_prescale
    $error("PRESCALE must be >= NUM_CH");
  end

  logic [TICK_W-1:0] tick;
  logic              tick_stb_unused;

  bemicro_cv_tick_gen #(
    .PRESCALE  (PRESCALE),
    .TICK_INIT (TICK_INIT)
  ) u_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .tick_stb (tick_stb_unused)
  );

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] armed;
  logic [TICK_W-1:0] deadline [NUM_CH];
  logic [TICK_W-1:0] period   [NUM_CH];
  logic [15:0]       cmp_low;
  logic [15:0]       tick_hi_shadow;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  scan_idx;
`ifdef VTIMER_OVERRUN_EN
  logic [NUM_CH-1:0] overrun;
`endif

  logic              wr_en;
  logic              rd_en;
  logic              sel_ok;
  logic              host_conflict;
  logic              scan_fire;
  logic [NUM_CH-1:0] wmask;
  logic [15:0]       rdata;

  assign wr_en  = chipselect & ~write_n;
  assign rd_en  = chipselect &  write_n;
  assign sel_ok = (32'(sel) < NUM_CH);
  assign wmask  = writedata[NUM_CH-1:0];
  assign irq    = |(pending & enable);

  // A host re-arm or disarm of the channel under scan supersedes this
  // cycle's comparison so the host's view of the channel is never overwritten.
  assign host_conflict = wr_en &&
                         (((address == ADDR_CMP_H) && (sel == scan_idx)) ||
                          ((address == ADDR_ARMED) && writedata[scan_idx]));

  assign scan_fire = armed[scan_idx] && !host_conflict &&
                     deadline_reached(tick, deadline[scan_idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      enable   <= '0;
      armed    <= '0;
      cmp_low  <= '0;
      sel      <= '0;
      scan_idx <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        deadline[i] <= '0;
        period[i]   <= '0;
      end
`ifdef VTIMER_OVERRUN_EN
      overrun  <= '0;
`endif
    end else begin
      scan_idx <= (scan_idx == SEL_W'(NUM_CH - 1)) ? '0 : scan_idx + SEL_W'(1);

      if (wr_en) begin
        case (address)
          ADDR_STATUS: pending <= pending & ~wmask;
          ADDR_ENABLE: enable  <= wmask;
          ADDR_SEL:    sel     <= writedata[SEL_W-1:0];
          ADDR_CMP_L:  cmp_low <= writedata;
          ADDR_CMP_H: begin
            if (sel_ok) begin
              deadline[sel] <= {writedata, cmp_low};
              armed[sel]    <= 1'b1;
              pending[sel]  <= 1'b0;
            end
          end
          ADDR_PER_L: if (sel_ok) period[sel][15:0]  <= writedata;
          ADDR_PER_H: if (sel_ok) period[sel][31:16] <= writedata;
          ADDR_ARMED:  armed   <= armed & ~wmask;
`ifdef VTIMER_OVERRUN_EN
          ADDR_OVERRUN: overrun <= overrun & ~wmask;
`endif
          default: ;
        endcase
      end

      // Placed after the host writes so a same-cycle W1C loses to a new event.
      if (scan_fire) begin
        pending[scan_idx] <= 1'b1;
`ifdef VTIMER_OVERRUN_EN
        if (pending[scan_idx]) begin
          overrun[scan_idx] <= 1'b1;
        end
`endif
        if (period[scan_idx] == '0) begin
          armed[scan_idx] <= 1'b0;
        end else begin
          deadline[scan_idx] <= deadline[scan_idx] + period[scan_idx];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_STATUS: rdata[NUM_CH-1:0] = pending;
      ADDR_ENABLE: rdata[NUM_CH-1:0] = enable;
      ADDR_TICK_L: rdata = tick[15:0];
      ADDR_TICK_H: rdata = tick_hi_shadow;
      ADDR_SEL:    rdata[SEL_W-1:0]  = sel;
      ADDR_CMP_L:  rdata = cmp_low;
      ADDR_CMP_H:  if (sel_ok) rdata = deadline[sel][31:16];
      ADDR_PER_L:  if (sel_ok) rdata = period[sel][15:0];
      ADDR_PER_H:  if (sel_ok) rdata = period[sel][31:16];
      ADDR_ARMED:  rdata[NUM_CH-1:0] = armed;
`ifdef VTIMER_OVERRUN_EN
      ADDR_OVERRUN: rdata[NUM_CH-1:0] = overrun;
`endif
      default: ;
    endcase
  end

  // Reading TICK_L freezes the upper half so a following TICK_H read is coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata       <= '0;
      tick_hi_shadow <= '0;
    end else begin
      readdata <= rd_en ? rdata : '0;
      if (rd_en && (address == ADDR_TICK_L)) begin
        tick_hi_shadow <= tick[31:16];
      end
    end
  end

endmodule

// File: tb/tb_bemicro_cv_vtimer_sched.sv
// Directed self-checking bench for bemicro_cv_vtimer_sched.
// Two instances share clock, reset and bus lines: dut starts at tick 0,
// dut_w starts just below the 32-bit wrap. Each has its own chipselect.
module tb_bemicro_cv_vtimer_sched;

  localparam int unsigned NCH  = 4;
  localparam int unsigned PS   = 4;
  localparam logic [31:0] WINIT = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        chipselect_w = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [15:0] readdata_w;
  logic        irq;
  logic        irq_w;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc;

  always #5 clk = ~clk;

  bemicro_cv_vtimer_sched #(
    .NUM_CH    (NCH),
    .PRESCALE  (PS),
    .TICK_INIT (32'h0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  bemicro_cv_vtimer_sched #(
    .NUM_CH    (NCH),
    .PRESCALE  (PS),
    .TICK_INIT (WINIT)
  ) dut_w (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect_w),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata_w),
    .irq        (irq_w)
  );

  // Edges since reset release; edge n is the n-th posedge with reset_n high.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Tick value the DUT held just before edge n.
  function automatic logic [31:0] tick_before(input int unsigned n, input logic [31:0] init);
    return init + 32'((n - 1) / PS);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic bus_wr(input bit w, input logic [3:0] a, input logic [15:0] d);
    address = a; writedata = d; write_n = 1'b0;
    chipselect = ~w; chipselect_w = w;
    @(posedge clk); #1;
    chipselect = 1'b0; chipselect_w = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input bit w, input logic [3:0] a, output logic [15:0] d);
    address = a; write_n = 1'b1;
    chipselect = ~w; chipselect_w = w;
    @(posedge clk); #1;
    chipselect = 1'b0; chipselect_w = 1'b0;
    d = w ? readdata_w : readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_irq(input bit w, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (w ? irq_w : irq) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    bit          seen;
    logic [3:0]  zaddr [10];
    zaddr = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

    #2;
    // ---- reset state ----
    do_reset();
    check("reset_irq", 32'(irq), 32'd0);
    bus_rd(0, 4'd2, d); check("reset_tick_l", 32'(d), 32'd0);   // edge 1
    bus_rd(0, 4'd3, d); check("reset_tick_h", 32'(d), 32'd0);   // edge 2
    for (int i = 0; i < 10; i++) begin                           // edges 3..12
      bus_rd(0, zaddr[i], d);
      check($sformatf("reset_rd_a%0d", zaddr[i]), 32'(d), 32'd0);
    end
    bus_rd(0, 4'd2, d); check("tick_l_after_3_ticks", 32'(d), 32'd3); // edge 13

    // ---- ch0 one-shot at deadline 5 ----
    bus_wr(0, 4'd1, 16'h0001);   // ENABLE
    bus_wr(0, 4'd4, 16'h0000);   // SEL=0
    bus_wr(0, 4'd5, 16'h0005);   // CMP_L
    bus_wr(0, 4'd6, 16'h0000);   // CMP_H -> arm
    wait_irq(0, 40, seen);
    check("oneshot_irq_seen", 32'(seen), 32'd1);
    check("oneshot_fire_tick", tick_before(cyc, 32'h0), 32'd5);
    bus_rd(0, 4'd9, d); check("oneshot_armed_cleared", 32'(d), 32'd0);
    bus_rd(0, 4'd0, d); check("oneshot_status", 32'(d), 32'd1);
    bus_wr(0, 4'd0, 16'h0001);
    check("oneshot_irq_after_w1c", 32'(irq), 32'd0);
    bus_rd(0, 4'd0, d); check("oneshot_status_after_w1c", 32'(d), 32'd0);

    // ---- ch2 periodic: deadline 2, period 3 ----
    do_reset();
    bus_wr(0, 4'd1, 16'h0004);   // ENABLE ch2
    bus_wr(0, 4'd4, 16'h0002);   // SEL=2
    bus_wr(0, 4'd7, 16'h0003);   // PER_L
    bus_wr(0, 4'd5, 16'h0002);   // CMP_L
    bus_wr(0, 4'd6, 16'h0000);   // CMP_H -> arm
    for (int k = 0; k < 3; k++) begin
      wait_irq(0, 40, seen);
      check($sformatf("periodic_seen_%0d", k), 32'(seen), 32'd1);
      check($sformatf("periodic_tick_%0d", k), tick_before(cyc, 32'h0), 32'(2 + 3 * k));
      bus_wr(0, 4'd0, 16'h0004);
      bus_rd(0, 4'd9, d); check($sformatf("periodic_armed_%0d", k), 32'(d), 32'h4);
      bus_rd(0, 4'd6, d); check($sformatf("periodic_cmp_h_%0d", k), 32'(d), 32'h0);
    end

    // ---- reset mid-operation ----
    do_reset();
    bus_rd(0, 4'd9, d); check("midreset_armed", 32'(d), 32'h0);
    bus_rd(0, 4'd4, d); check("midreset_sel", 32'(d), 32'h0);
    bus_rd(0, 4'd1, d); check("midreset_enable", 32'(d), 32'h0);

    // ---- CMP_H write collides with ch1 scan that would fire ----
    do_reset();
    bus_wr(0, 4'd4, 16'h0001);   // edge 1: SEL=1
    bus_wr(0, 4'd5, 16'h0000);   // edge 2: CMP_L=0
    bus_wr(0, 4'd6, 16'h0000);   // edge 3: arm at deadline 0 (already due)
    idle(2);                     // edges 4,5
    bus_wr(0, 4'd6, 16'h0001);   // edge 6: ch1 under scan, re-arm at 0x10000
    idle(8);
    bus_rd(0, 4'd0, d); check("collide_pending", 32'(d), 32'h0);
    bus_rd(0, 4'd9, d); check("collide_armed", 32'(d), 32'h2);
    bus_rd(0, 4'd6, d); check("collide_new_deadline_h", 32'(d), 32'h1);

    // ---- STATUS W1C in the same cycle as a set on ch3 ----
    do_reset();
    bus_wr(0, 4'd4, 16'h0003);   // edge 1: SEL=3
    bus_wr(0, 4'd6, 16'h0000);   // edge 2: arm ch3 at deadline 0
    idle(1);                     // edge 3
    bus_wr(0, 4'd0, 16'h0008);   // edge 4: ch3 scanned and fires
    bus_rd(0, 4'd0, d); check("w1c_vs_set_pending", 32'(d), 32'h8);
    bus_rd(0, 4'd9, d); check("w1c_vs_set_armed", 32'(d), 32'h0);

    // ---- overrun ----
    do_reset();
`ifdef VTIMER_OVERRUN_EN
    bus_wr(0, 4'd7, 16'h0001);   // edge 1: period 1 on ch0
    bus_wr(0, 4'd6, 16'h0000);   // edge 2: arm at deadline 0
    idle(8);                     // fires at edges 5 and 9
    bus_rd(0, 4'd10, d); check("overrun_set", 32'(d), 32'h1);
    bus_rd(0, 4'd0, d);  check("overrun_pending", 32'(d), 32'h1);
    bus_wr(0, 4'd9, 16'h0001);   // disarm
    bus_wr(0, 4'd10, 16'h0001);  // W1C overrun
    bus_rd(0, 4'd10, d); check("overrun_cleared", 32'(d), 32'h0);
`else
    bus_wr(0, 4'd10, 16'hFFFF);
    bus_rd(0, 4'd10, d); check("overrun_absent_reads_0", 32'(d), 32'h0);
`endif

    // ---- wrap-safe compare on dut_w (tick starts at 0xFFFFFFFE) ----
    do_reset();
    bus_rd(1, 4'd2, d); check("wrap_tick_l", 32'(d), 32'hFFFE);   // edge 1
    bus_rd(1, 4'd3, d); check("wrap_tick_h", 32'(d), 32'hFFFF);   // edge 2
    bus_wr(1, 4'd5, 16'h0001);   // edge 3: CMP_L
    bus_wr(1, 4'd6, 16'h0000);   // edge 4: arm at 0x00000001
    bus_wr(1, 4'd1, 16'h0001);   // edge 5: ENABLE
    wait_irq(1, 40, seen);
    check("wrap_irq_seen", 32'(seen), 32'd1);
    check("wrap_fire_tick", tick_before(cyc, WINIT), 32'h1);
    bus_rd(1, 4'd2, d); check("wrap_tick_l_after", 32'(d), 32'h1);
    bus_rd(1, 4'd3, d); check("wrap_tick_h_after", 32'(d), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
